// File: rtl/conv_encoder_k9.sv
// conv_encoder_k9: rate-1/2 K=9 feed-forward convolutional encoder with zero-tail termination.
// Optional rate-2/3 puncture mask enabled by defining CONV_ENC_PUNCTURE_EN.  Rev 1.0
`default_nettype none

module conv_encoder_k9 #(
  parameter int             K  = 9,
  parameter logic [K-1:0]   G0 = 9'o561,
  parameter logic [K-1:0]   G1 = 9'o753
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_e,
  input  logic       i_start,
  input  logic       i_data,
  input  logic       i_data_vld,
  input  logic       i_last,
  output logic       o_data_rdy,
  output logic [1:0] o_sym,
  output logic       o_sym_vld,
  output logic [1:0] o_sym_msk,
  input  logic       i_sym_rdy,
  output logic       o_busy,
  output logic       o_done
);

  localparam int SW = K - 1;
  localparam int CW = $clog2(SW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   sr_q;
  logic [CW-1:0]   tail_cnt_q;
  logic [1:0]      sym_q;
  logic            sym_vld_q;
  logic            done_q;

  logic            slot_free;
  logic            load;
  logic            enc_bit;
  logic [K-1:0]    v;
  logic [1:0]      sym_d;

  // sr_q[SW-1] holds the most recent previous bit, so v lines up with the generator taps.
  assign slot_free = !sym_vld_q || i_sym_rdy;
  assign load      = en_e && slot_free &&
                     (((state_q == ST_DATA) && i_data_vld) || (state_q == ST_TAIL));
  assign enc_bit   = (state_q == ST_TAIL) ? 1'b0 : i_data;
  assign v         = {enc_bit, sr_q};
  assign sym_d     = {^(v & G1), ^(v & G0)};

  assign o_data_rdy = en_e && (state_q == ST_DATA) && slot_free;
  assign o_sym      = sym_q;
  assign o_sym_vld  = sym_vld_q;
  assign o_busy     = (state_q == ST_DATA) || (state_q == ST_TAIL);
  assign o_done     = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      tail_cnt_q <= '0;
      sym_q      <= '0;
      sym_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (en_e) begin
        if (load) begin
          sym_q     <= sym_d;
          sym_vld_q <= 1'b1;
          sr_q      <= {enc_bit, sr_q[SW-1:1]};
        end else if (i_sym_rdy) begin
          sym_vld_q <= 1'b0;
        end
        case (state_q)
          ST_IDLE: begin
            if (i_start) begin
              sr_q    <= '0;
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (load && i_last) begin
              state_q    <= ST_TAIL;
              tail_cnt_q <= '0;
            end
          end
          ST_TAIL: begin
            if (load) begin
              tail_cnt_q <= tail_cnt_q + 1'b1;
              if (tail_cnt_q == CW'(SW - 1)) state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (slot_free) begin
              done_q  <= 1'b1;
              sr_q    <= '0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CONV_ENC_PUNCTURE_EN
  logic       phase_q;
  logic [1:0] msk_q;

  // Mask travels with its symbol; phase advances on every issued symbol, tail included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= 1'b0;
      msk_q   <= 2'b11;
    end else if (en_e) begin
      if ((state_q == ST_IDLE) && i_start) begin
        phase_q <= 1'b0;
      end else if (load) begin
        phase_q <= ~phase_q;
        msk_q   <= phase_q ? 2'b01 : 2'b11;
      end
    end
  end

  assign o_sym_msk = msk_q;
`else
  assign o_sym_msk = 2'b11;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder_k9.sv
// tb_conv_encoder_k9: randomized self-checking bench for conv_encoder_k9 against a convolution-sum model.
`timescale 1ns/1ps
`default_nettype none

module tb_conv_encoder_k9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_e = 1'b1;
  logic       i_start = 1'b0;
  logic       i_data = 1'b0;
  logic       i_data_vld = 1'b0;
  logic       i_last = 1'b0;
  logic       i_sym_rdy = 1'b0;
  logic       o_data_rdy;
  logic [1:0] o_sym;
  logic       o_sym_vld;
  logic [1:0] o_sym_msk;
  logic       o_busy;
  logic       o_done;

  conv_encoder_k9 dut (
    .clk        (clk),
    .rst        (rst),
    .en_e       (en_e),
    .i_start    (i_start),
    .i_data     (i_data),
    .i_data_vld (i_data_vld),
    .i_last     (i_last),
    .o_data_rdy (o_data_rdy),
    .o_sym      (o_sym),
    .o_sym_vld  (o_sym_vld),
    .o_sym_msk  (o_sym_msk),
    .i_sym_rdy  (i_sym_rdy),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       i_sym_rdy = 1'b1;
      1:       i_sym_rdy = 1'($urandom_range(0, 1));
      default: i_sym_rdy = 1'b0;
    endcase
  end

  // Output monitor: records accepted beats and flags any change while stalled.
  logic [1:0] obs_sym[$];
  logic [1:0] obs_msk[$];
  int         obs_cyc[$];
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_sym = 2'b00;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!o_sym_vld || (o_sym !== prev_sym))) stall_err++;
      if (o_sym_vld && i_sym_rdy && en_e) begin
        obs_sym.push_back(o_sym);
        obs_msk.push_back(o_sym_msk);
        obs_cyc.push_back(cyc);
      end
      prev_stall = o_sym_vld && !(i_sym_rdy && en_e);
      prev_sym   = o_sym;
    end
  end

  // Reference model: each symbol bit is the GF(2) convolution of the zero-tailed bit stream with a generator.
  bit         frame_q[$];
  logic [1:0] exp_sym[$];
  int         done_cyc;

  task automatic build_model();
    logic [8:0] g0;
    logic [8:0] g1;
    logic       s0;
    logic       s1;
    int         n;
    g0 = 9'o561;
    g1 = 9'o753;
    n  = frame_q.size();
    exp_sym.delete();
    for (int i = 0; i < n + 8; i++) begin
      s0 = 1'b0;
      s1 = 1'b0;
      for (int j = 0; j < 9; j++) begin
        if ((i - j >= 0) && (i - j < n) && frame_q[i - j]) begin
          s0 ^= g0[8 - j];
          s1 ^= g1[8 - j];
        end
      end
      exp_sym.push_back({s1, s0});
    end
  endtask

  task automatic rand_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic run_frame(input int mode, input bit freeze, output int data_stalls);
    int         t;
    logic [7:0] snap;
    obs_sym.delete();
    obs_msk.delete();
    obs_cyc.delete();
    stall_err   = 0;
    data_stalls = 0;
    build_model();
    rdy_mode = mode;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      i_data     = frame_q[i];
      i_data_vld = 1'b1;
      i_last     = (i == frame_q.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (o_data_rdy) break;
        data_stalls++;
        t++;
        if (t > 200) begin
          checks++; errors++;
          $display("FAIL accept_timeout: bit %0d not accepted within 200 cycles, expected acceptance", i);
          i_data_vld = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    i_data_vld = 1'b0;
    i_last     = 1'b0;
    if (freeze) begin
      repeat (3) @(posedge clk);
      #1 en_e = 1'b0;
      rdy_mode = 2;
      @(negedge clk);
      snap = {o_sym, o_sym_vld, o_sym_msk, o_busy, o_data_rdy, o_done};
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL freeze_in_tail: o_busy=%0b, expected 1", o_busy);
      end
      repeat (4) begin
        @(negedge clk);
        checks++;
        if ({o_sym, o_sym_vld, o_sym_msk, o_busy, o_data_rdy, o_done} !== snap) begin
          errors++;
          $display("FAIL freeze_hold: outputs=%b, expected %b",
                   {o_sym, o_sym_vld, o_sym_msk, o_busy, o_data_rdy, o_done}, snap);
        end
      end
      @(posedge clk); #1 en_e = 1'b1;
      rdy_mode = mode;
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (o_done) break;
      t++;
      if (t > 500) begin
        checks++; errors++;
        $display("FAIL done_timeout: o_done not seen within 500 cycles, expected a pulse");
        return;
      end
    end
    done_cyc = cyc;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: o_busy=%0b, expected 0", o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: o_done=%0b one cycle later, expected 0", o_done);
    end
  endtask

  task automatic check_frame(input string name);
    int         n;
    logic [1:0] em;
    checks++;
    if (obs_sym.size() != exp_sym.size()) begin
      errors++;
      $display("FAIL %s_beats: got %0d beats, expected %0d", name, obs_sym.size(), exp_sym.size());
    end
    n = (obs_sym.size() < exp_sym.size()) ? obs_sym.size() : exp_sym.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_sym[i] !== exp_sym[i]) begin
        errors++;
        $display("FAIL %s_sym[%0d]: got %b, expected %b", name, i, obs_sym[i], exp_sym[i]);
      end
`ifdef CONV_ENC_PUNCTURE_EN
      em = (i % 2 == 1) ? 2'b01 : 2'b11;
`else
      em = 2'b11;
`endif
      checks++;
      if (obs_msk[i] !== em) begin
        errors++;
        $display("FAIL %s_msk[%0d]: got %b, expected %b", name, i, obs_msk[i], em);
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL %s_stall_stable: %0d changes while stalled, expected 0", name, stall_err);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({o_sym, o_sym_vld, o_sym_msk, o_data_rdy, o_busy, o_done} !== 8'b00_0_11_000) begin
      errors++;
      $display("FAIL %s: outputs sym,vld,msk,rdy,busy,done=%b, expected 00011000", name,
               {o_sym, o_sym_vld, o_sym_msk, o_data_rdy, o_busy, o_done});
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2 check_reset_values("reset_async");
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_impulse();
    logic [1:0] imp[9];
    int         st;
    imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b11};
    frame_q.delete();
    frame_q.push_back(1'b1);
    run_frame(0, 1'b0, st);
    check_frame("impulse");
    for (int i = 0; i < 9 && i < obs_sym.size(); i++) begin
      checks++;
      if ({obs_sym[i][0], obs_sym[i][1]} !== imp[i]) begin
        errors++;
        $display("FAIL impulse_table[%0d]: (s0,s1)=%b, expected %b", i,
                 {obs_sym[i][0], obs_sym[i][1]}, imp[i]);
      end
    end
    if (obs_cyc.size() > 0) begin
      checks++;
      if (done_cyc != obs_cyc[obs_cyc.size() - 1] + 1) begin
        errors++;
        $display("FAIL impulse_done_latency: done at cycle %0d, expected %0d", done_cyc,
                 obs_cyc[obs_cyc.size() - 1] + 1);
      end
    end
  endtask

  task automatic test_throughput();
    int st;
    rand_frame(64);
    run_frame(0, 1'b0, st);
    check_frame("throughput");
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL throughput_data_rdy: %0d stalled data cycles, expected 0", st);
    end
    if (obs_cyc.size() == 72) begin
      checks++;
      if (obs_cyc[71] - obs_cyc[0] != 71) begin
        errors++;
        $display("FAIL throughput_consecutive: span %0d cycles, expected 71", obs_cyc[71] - obs_cyc[0]);
      end
      checks++;
      if (done_cyc != obs_cyc[71] + 1) begin
        errors++;
        $display("FAIL throughput_done_latency: done at %0d, expected %0d", done_cyc, obs_cyc[71] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int st;
    run_frame(1, 1'b0, st);
    check_frame("backpressure");
  endtask

  task automatic test_enable_freeze();
    int st;
    rand_frame(16);
    run_frame(0, 1'b1, st);
    check_frame("freeze");
  endtask

  task automatic test_reset_midframe();
    int st;
    rand_frame(20);
    rdy_mode = 0;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_data     = frame_q[i];
      i_data_vld = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: o_busy=%0b, expected 1", o_busy);
    end
    rst = 1'b0;
    #1 check_reset_values("midframe_reset");
    i_data_vld = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    rand_frame(12);
    run_frame(0, 1'b0, st);
    check_frame("after_reset");
  endtask

  task automatic test_puncture();
    int st;
    rand_frame(4);
    run_frame(0, 1'b0, st);
    check_frame("puncture");
  endtask

  task automatic test_back_to_back();
    int st;
    for (int f = 0; f < 3; f++) begin
      rand_frame($urandom_range(1, 24));
      run_frame(f == 1 ? 1 : 0, 1'b0, st);
      check_frame("back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_throughput();
    test_backpressure();
    test_enable_freeze();
    test_reset_midframe();
    test_puncture();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_encoder_k9.md
Name: conv_encoder_k9

Overview:
- Rate-1/2 feed-forward convolutional encoder, K=9, 256 states. Transmit-side counterpart of the Viterbi decoder.
- Its state convention matches the decoder's trellis: next state = {bit, state[7:1]}.
- Accepts a frame of data bits over a valid/ready handshake and emits one 2-bit code symbol per bit.
- Zero-terminates every frame with K-1 tail bits, so the decoder's traceback ends in state 0.

Parameters:
- K, 9, constraint length; state width = K-1 = 8.
- G0, 9'o561, generator polynomial for symbol bit 0; bit K-1 taps the current input.
- G1, 9'o753, generator polynomial for symbol bit 1; bit K-1 taps the current input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en_e  input  1  block enable; when low, all state is frozen.
- i_start  input  1  single-cycle frame start; honoured only in IDLE.
- i_data  input  1  data bit.
- i_data_vld  input  1  i_data is valid.
- i_last  input  1  qualifies the final data bit of the frame.
- o_data_rdy  output  1  encoder accepts i_data this cycle.
- o_sym  output  2  code symbol; [0]=G0 output, [1]=G1 output.
- o_sym_vld  output  1  o_sym is valid.
- o_sym_msk  output  2  per-bit transmit mask (see Optional Feature).
- i_sym_rdy  input  1  downstream accepts o_sym.
- o_busy  output  1  high in DATA and TAIL.
- o_done  output  1  one-cycle pulse after the last tail symbol is accepted.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; sr=0; tail count=0; puncture phase=0.
- Reset values of outputs: o_sym=0, o_sym_vld=0, o_sym_msk=2'b11, o_data_rdy=0, o_busy=0, o_done=0.
- A reset mid-frame discards the frame; no partial tail is sent.
- Encoding: v = {b, sr[7:0]}, where sr[7] is the most recent previous bit.
  - o_sym[0] = ^(v & G0); o_sym[1] = ^(v & G1).
  - On each accepted bit: sr <= {b, sr[7:1]}.
- Output slot free: slot_free = !o_sym_vld || i_sym_rdy.
- Single registered output stage; latency 1 cycle from acceptance to o_sym_vld.
- o_sym and o_sym_vld are held stable while o_sym_vld && !i_sym_rdy.
- o_data_rdy = en_e && FSM==DATA && slot_free. It is combinational from registered state and i_sym_rdy.
- A bit is accepted when i_data_vld && o_data_rdy.
- FSM transitions:
  - IDLE: i_start && en_e -> clear sr, go to DATA.
  - DATA: accepted bit with i_last=1 -> go to TAIL, tail count=0.
  - TAIL: each cycle with en_e && slot_free, encode b=0 and increment the count. After K-1=8 tail symbols are issued -> DRAIN.
  - DRAIN: wait until the last symbol is accepted (o_sym_vld=0 or i_sym_rdy=1). Then pulse o_done for 1 cycle, sr=0, go to IDLE.
- o_sym_vld clears when the symbol is accepted and no new symbol is loaded in the same cycle.
- Simultaneous accept-out and load-in in the same cycle sustains 1 symbol/cycle throughput.
- i_start outside IDLE is ignored. i_data_vld in IDLE, TAIL or DRAIN is ignored (o_data_rdy=0).
- en_e=0: no acceptance, no FSM, sr or counter change; outputs hold. o_done is not generated while en_e=0.
- Frame of N bits yields exactly N+8 symbol beats. The final state is 0.

Optional Feature:
- Macro: CONV_ENC_PUNCTURE_EN.
- Defined: rate-2/3 puncturing with period-2 pattern.
  - Phase 0: o_sym_msk=2'b11.
  - Phase 1: o_sym_msk=2'b01 (G1 bit not transmitted).
  - The phase toggles on each issued symbol, including tail symbols, and resets to 0 at i_start.
  - o_sym still carries both computed bits; downstream uses the mask.
- Not defined: o_sym_msk is constant 2'b11 and no phase register exists.

Test Plan:
- Impulse: i_start, then one bit 1 with i_last, i_sym_rdy=1.
  - Expected: 9 symbols, (o_sym[0],o_sym[1]) = 11,01,11,11,10,01,00,01,11.
  - Then o_done pulses 1 cycle after the last beat; o_busy=0.
- Throughput: 64-bit random frame, i_sym_rdy=1, i_data_vld=1.
  - Expected: o_data_rdy high every DATA cycle; 72 consecutive beats; symbols match the reference model.
  - Expected: internal sr=0 at o_done.
- Backpressure: same frame with i_sym_rdy toggling at random.
  - Expected: o_sym stable while stalled; no beat lost or duplicated; count=N+8.
- Enable freeze: en_e=0 for 5 cycles mid-TAIL.
  - Expected: tail count, sr and outputs are unchanged.
  - Expected: after resume, exactly the remaining tail symbols are issued.
- Reset mid-frame: assert rst during DATA after 10 bits.
  - Expected: all outputs take reset values immediately; a new frame encodes from state 0.
- CONV_ENC_PUNCTURE_EN: 4-bit frame.
  - Expected: o_sym_msk sequence 11,01,11,01,... over all 12 beats.
  - Expected: with the macro undefined, the mask is 11 throughout.
